aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-schedule engine that sits directly upstream of the `AES2` cipher core. It accepts a 128-bit cipher key over a valid/ready handshake and computes the 11 round keys, one round per clock. The keys are held in an internal register file. The cipher core reads them through an indexed port: ascending order for encryption, descending order for decryption.

## Interface
Parameters:
- `ROUNDS`, default 10: number of expansion rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `key_valid`  in  1: `key` is presented for loading.
- `key_ready`  out  1: engine can accept a new key.
- `key`  in  128: cipher key, word w0 in bits [127:96].
- `keys_valid`  out  1: all 11 round keys are stored and stable.
- `round_idx`  in  4: round-key read index, 0..10.
- `round_key`  out  128: registered round key for the `round_idx` sampled on the previous edge.

## Operation
- State machine IDLE → EXPAND → DONE.
- Accept event: `key_valid && key_ready` on a rising edge.
  - The key is stored as round key 0.
  - The round counter is set to 1.
  - The state goes to EXPAND.
  - `keys_valid` is cleared.
- EXPAND, one round per cycle with counter r = 1..10:
  - temp = SubWord(RotWord(w3 of key r-1)) xor {Rcon[r], 24'h0}.
  - w0' = w0 xor temp; w1' = w1 xor w0'; w2' = w2 xor w1'; w3' = w3 xor w2'.
  - The result is written as round key r.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- All arithmetic is GF(2^8) xor/S-box only; there are no carries.
- After the edge that writes r = 10, the state goes to DONE and `keys_valid` rises.
- `key_ready`: 1 in IDLE and DONE, 0 in EXPAND.
  - `key_valid` during EXPAND is ignored; the key is not queued.
- In DONE, a new accept restarts expansion. `keys_valid` drops on the accept edge.
- Read port:
  - `round_key` <= regfile[`round_idx`] every cycle.
  - `round_idx` > 10 yields 128'h0.
  - Reads are allowed in any state; data is meaningful only while `keys_valid` = 1.
- Simultaneous accept and read in DONE: the read returns the old key r. Register 0 is overwritten on the same edge, so reads of index 0 after that edge return the new key.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `key_ready` 1, `keys_valid` 0, `round_key` 0.
  - All 11 regfile entries 0.
- Reset asserted mid-expansion: immediate return to IDLE, all keys cleared. No partial result survives.
- Latency:
  - Accept at edge T0.
  - Round k is written at edge T0+k.
  - `keys_valid` = 1 after edge T0+10.
  - `key_ready` = 0 from T0 to T0+10.
- Read latency is 1 cycle: index at edge T, data valid after edge T+1. This supports full-throughput sequential reads by the core, one index per cycle.
- The SubWord path uses 4 S-box lookups in one cycle. The critical path is S-box + 2 xor levels + 4-deep xor chain.

## Structure
- Shared package `aes_pkg`:
  - Rcon table, 10×8-bit.
  - `round_key_t` (128-bit), `word_t` (32-bit).
  - Constant `AES128_ROUNDS = 10`.
  - Function-free S-box constant table.
  - The package is shared with `AES2`.
- Sub-module `aes_sbox`: one byte in, one byte out, combinational ROM. Four instances for SubWord. `AES2` reuses the same module.
- Top level: FSM + counter, key-schedule round logic, 11×128 regfile, read register.

## Test plan
- FIPS-197 A.1 key: accept key 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 1 reads a0fafe1788542cb123a339392a6c7605.
  - Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `keys_valid` rises exactly 10 cycles after accept.
- All-zero key: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Handshake:
  - `key_valid` pulsed during EXPAND is ignored; round keys are unchanged and `key_ready` stays 0.
  - Re-accept in DONE clears `keys_valid` on that edge and recomputes.
- Reset at cycle 5 of expansion:
  - All outputs return to reset values, `key_ready` = 1.
  - A subsequent full run produces correct keys.
- Read port:
  - Sweep `round_idx` 10 down to 0, one per cycle; each key appears one cycle after its index.
  - Index 11 and 15 return 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and types: round constants, S-box ROM contents and
// the word / round-key types. Also used by the AES2 cipher core.
package aes_pkg;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef logic [127:0] round_key_t;
  typedef logic [31:0]  word_t;

  // Round constants for rounds 1..10, stored at index r-1
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, indexed by the input byte
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box ROM.
//   data    : input byte
//   subst_c : substituted byte (combinational)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst_c
);

  assign subst_c = SBOX[data];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file, read back through a registered indexed port.
//   clock, reset_n    : clock, async active-low reset
//   key_valid/ready   : key load handshake, key word w0 in [127:96]
//   keys_valid        : all round keys stored and stable
//   round_idx         : read index 0..10 (others read as zero)
//   round_key         : registered key for round_idx of the previous edge
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS = AES128_ROUNDS
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         keys_valid,
  input  logic [3:0]   round_idx,
  output logic [127:0] round_key
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_d, valid_d;
  logic             accept;

  round_key_t       rk [ROUNDS+1];
  round_key_t       cur;
  round_key_t       next_key;

  word_t            w0, w1, w2, w3;
  word_t            rot, sub, temp;
  word_t            n0, n1, n2, n3;
  logic [CNT_W-1:0] rcon_idx;
  logic [7:0]       rcon;

  // Key schedule round on the most recently written round key
  assign w0  = cur[127:96];
  assign w1  = cur[95:64];
  assign w2  = cur[63:32];
  assign w3  = cur[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data    (rot[8*b +: 8]),
      .subst_c (sub[8*b +: 8])
    );
  end

  // Counter is 1..ROUNDS while expanding; clamp so idle values stay in range
  assign rcon_idx = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
  assign rcon     = RCON[rcon_idx];
  assign temp     = sub ^ {rcon, 24'h0};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // key_ready is registered and mirrors "not expanding"
  assign accept = key_valid && key_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_ready  <= 1'b1;
      keys_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_ready  <= ready_d;
      keys_valid <= valid_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = key_ready;
    valid_d = keys_valid;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_EXPAND;
          cnt_d   = CNT_W'(1);
          ready_d = 1'b0;
          valid_d = 1'b0;
        end
      end
      S_EXPAND: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          ready_d = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Round-key register file; cur shadows the last entry written
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= '0;
      for (int i = 0; i <= int'(ROUNDS); i++) begin
        rk[i] <= '0;
      end
    end else if (accept) begin
      cur   <= key;
      rk[0] <= key;
    end else if (state_q == S_EXPAND) begin
      cur <= next_key;
      for (int i = 1; i <= int'(ROUNDS); i++) begin
        if (cnt_q == CNT_W'(i)) begin
          rk[i] <= next_key;
        end
      end
    end
  end

  // Registered read port; out-of-range indices read zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      round_key <= '0;
    end else if (round_idx <= LAST) begin
      round_key <= rk[round_idx];
    end else begin
      round_key <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: table of known key vectors, an
// independent key-schedule model (S-box derived from GF(2^8) inverse and
// affine map) and a read-port scoreboard.
module tb_aes_key_expand;

  logic         clock;
  logic         reset_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         keys_valid;
  logic [3:0]   round_idx;
  logic [127:0] round_key;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  aes_key_expand #(.ROUNDS(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .keys_valid (keys_valid),
    .round_idx  (round_idx),
    .round_key  (round_key)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
    bit           pulse;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_clear();
    for (int r = 0; r < 11; r++) exp_rk[r] = '0;
  endtask

  // Count edges after the accept edge until keys_valid, optionally poking key_valid mid-expansion
  task automatic wait_valid(input logic [127:0] k, input bit pulse, input int start);
    int cyc;
    cyc = start;
    while (keys_valid !== 1'b1 && cyc < 20) begin
      if (pulse && cyc == 3) begin
        key = ~k;
        key_valid = 1'b1;
      end
      @(negedge clock);
      cyc++;
      key_valid = 1'b0;
      if (pulse && cyc == 4) chk("ready_low_in_expand", 128'(key_ready), 128'(0));
    end
    chk("valid_latency", 128'(cyc), 128'(10));
    chk("ready_after_done", 128'(key_ready), 128'(1));
  endtask

  task automatic run_expand(input logic [127:0] k, input bit pulse);
    @(negedge clock);
    key = k;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    chk("ready_low_after_accept", 128'(key_ready), 128'(0));
    chk("valid_low_after_accept", 128'(keys_valid), 128'(0));
    wait_valid(k, pulse, 0);
  endtask

  // Read indices 10..0 then 11 and 15, one per cycle; expected pushed at drive, popped one cycle later
  task automatic sweep(input logic [127:0] r1, input logic [127:0] r10);
    logic [127:0] q [$];
    logic [127:0] e;
    int           idx_q [$];
    int           idx, ri;
    for (int j = 0; j <= 13; j++) begin
      @(negedge clock);
      if (q.size() != 0) begin
        e  = q.pop_front();
        ri = idx_q.pop_front();
        chk($sformatf("rk_read_idx%0d", ri), round_key, e);
      end
      if (j <= 12) begin
        idx = (j <= 10) ? 10 - j : (j == 11 ? 11 : 15);
        round_idx = 4'(idx);
        if (idx > 10)       e = '0;
        else if (idx == 1)  e = r1;
        else if (idx == 10) e = r10;
        else                e = exp_rk[idx];
        q.push_back(e);
        idx_q.push_back(idx);
      end
    end
  endtask

  vec_t vecs [2];
  logic [127:0] k3;

  initial begin
    vecs[0] = '{key: 128'h0,
                r1:  128'h62636363626363636263636362636363,
                r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e, pulse: 1'b0};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                r1:  128'ha0fafe1788542cb123a339392a6c7605,
                r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, pulse: 1'b1};
    k3 = 128'h000102030405060708090a0b0c0d0e0f;

    reset_n   = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    round_idx = 4'd0;
    build_sbox();
    repeat (2) @(negedge clock);
    chk("reset_ready", 128'(key_ready), 128'(1));
    chk("reset_valid", 128'(keys_valid), 128'(0));
    chk("reset_round_key", round_key, 128'h0);
    reset_n = 1'b1;

    // Known vectors; the second run also re-accepts from DONE and pokes key_valid mid-expansion
    for (int v = 0; v < 2; v++) begin
      run_expand(vecs[v].key, vecs[v].pulse);
      model_expand(vecs[v].key);
      sweep(vecs[v].r1, vecs[v].r10);
    end

    // Accept in DONE with a simultaneous read of index 0
    @(negedge clock);
    round_idx = 4'd0;
    key       = k3;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    chk("simul_read_old_key", round_key, vecs[1].key);
    chk("simul_valid_dropped", 128'(keys_valid), 128'(0));
    @(negedge clock);
    chk("simul_read_new_key", round_key, k3);
    wait_valid(k3, 1'b0, 1);
    model_expand(k3);
    sweep(exp_rk[1], exp_rk[10]);

    // Reset five cycles into an expansion
    @(negedge clock);
    round_idx = 4'd3;
    key       = 128'h0;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midreset_ready", 128'(key_ready), 128'(1));
    chk("midreset_valid", 128'(keys_valid), 128'(0));
    chk("midreset_round_key", round_key, 128'h0);
    @(negedge clock);
    reset_n = 1'b1;
    model_clear();
    sweep(128'h0, 128'h0);
    run_expand(vecs[1].key, 1'b0);
    model_expand(vecs[1].key);
    sweep(vecs[1].r1, vecs[1].r10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
